wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Write-back port arbiter/scheduler for the register bank shared by the execution units.
//  Each unit requests the single regbank write port.
//  The arbiter grants one per cycle, round-robin, and drives the registered write (we/waddr/wdata).
//  It emits a one-hot release mask that clears the matching lock bit in the operand-fetch scoreboard.
//  Results carrying a stale tag (issued before a control-flow change) are granted but not written.
// PARAMETERS
//  N_REQ   5   number of requesting execution units (>=2)
//  TAG_W   4   width of the instruction-stream tag
// PORTS
//  clk        in   1            single clock; all state updates on posedge
//  reset      in   1            asynchronous, active-high; clears all state immediately
//  req        in   N_REQ        bit k: unit k holds a result for write-back
//  addr_in    in   N_REQ*5      unit k destination register, bits [5k+4:5k]
//  data_in    in   N_REQ*32     unit k result, bits [32k+31:32k]
//  tag_in     in   N_REQ*TAG_W  unit k result tag
//  cur_tag    in   TAG_W        tag of the live instruction stream
//  stall      in   1            regbank busy; no grant may issue while high
//  gnt        out  N_REQ        one-hot grant, 1-cycle pulse
//  we         out  1            regbank write enable
//  waddr      out  5            regbank write address
//  wdata      out  32           regbank write data
//  release    out  32           one-hot scoreboard clear (bit 0 never set)
//  state      out  2            FSM state, for debug
// BEHAVIOUR
//  Reset values: gnt=0, we=0, waddr=0, wdata=0, release=0, ptr=0, last=0, state=IDLE.
//  Arbitration (comb, cycle t):
//   - elig = req & ~last, where last = gnt register.
//   - Winner w = first set bit of elig scanning ptr, ptr+1, ... wrapping at N_REQ-1 -> 0.
//  Registered outputs (edge ending cycle t), when elig!=0 and stall=0:
//   - gnt = onehot(w); ptr = (w==N_REQ-1) ? 0 : w+1.
//   - waddr = addr_in[w]; wdata = data_in[w].
//   - we = (addr_in[w]!=0) && (tag_in[w]==cur_tag).
//   - release = (addr_in[w]!=0) ? 1<<addr_in[w] : 0.
//   - release is set regardless of tag, so stale locks are always freed.
//  Otherwise: gnt=0, we=0, release=0; waddr/wdata hold; ptr holds.
//  Latency: req visible at edge t gives gnt/we/release high during cycle t+1 (1 cycle).
//  Handshake:
//   - Unit keeps req, addr, data and tag stable until it observes gnt.
//   - Unit drops req (or presents its next result) in the cycle gnt is high.
//   - The 'last' mask blocks a double grant to a unit in that cycle.
//  FSM (registered; reflects the decision of the previous edge):
//   - IDLE : no eligible req. elig!=0 & !stall -> GRANT; elig!=0 & stall -> STALL.
//   - GRANT: grant issued. Same decision table as IDLE; elig==0 -> IDLE.
//   - STALL: request pending, blocked. stall falls -> GRANT (if elig) else IDLE.
//  Boundary conditions:
//   - All units requesting: grants rotate, each unit at most once per N_REQ cycles, no starvation.
//   - Only one unit requesting continuously: grants every other cycle, because of the 'last' mask.
//   - addr_in==0 (x0): granted, we=0, release=0.
//   - cur_tag changes in the same cycle as arbitration: compare against the value sampled at that edge.
//   - reset mid-grant: outputs drop to 0 asynchronously; a pending req is re-arbitrated after reset falls, starting from ptr=0.
// TESTING
//  1. Reset released, req=5'b00100, addr=7, data=0xDEADBEEF, tags match
//     -> next cycle gnt=00100, we=1, waddr=7, wdata=DEADBEEF, release=0x80.
//  2. req=11111 held (each unit drops after its gnt and re-raises)
//     -> gnt order 0,1,2,3,4,0; no unit granted twice within 5 grants.
//  3. Unit 1, addr=3, tag_in=2, cur_tag=5 -> gnt[1]=1, we=0, release=0x8.
//  4. stall=1 for 3 cycles with req=00010 pending -> gnt=0, state=STALL;
//     stall falls -> gnt=00010 next cycle, state=GRANT.
//  5. Unit 3, addr=0 -> gnt[3]=1, we=0, release=0.
//  6. reset asserted while gnt=01000 -> gnt, we, release=0 immediately; after reset, ptr=0.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: write-back request/grant bundle between execution units and the regbank arbiter
interface wb_arbiter_if #(
  parameter int N_REQ = 5,
  parameter int TAG_W = 4
);
  logic [N_REQ-1:0]       i_req;
  logic [N_REQ*5-1:0]     i_addr;
  logic [N_REQ*32-1:0]    i_data;
  logic [N_REQ*TAG_W-1:0] i_tag;
  logic [TAG_W-1:0]       i_cur_tag;
  logic                   i_stall;
  logic [N_REQ-1:0]       o_gnt;
  logic                   o_we;
  logic [4:0]             o_waddr;
  logic [31:0]            o_wdata;
  logic [31:0]            o_release;
  logic [1:0]             o_state;
  modport slave (
    input  i_req, i_addr, i_data, i_tag, i_cur_tag, i_stall,
    output o_gnt, o_we, o_waddr, o_wdata, o_release, o_state
  );
  modport master (
    output i_req, i_addr, i_data, i_tag, i_cur_tag, i_stall,
    input  o_gnt, o_we, o_waddr, o_wdata, o_release, o_state
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin regbank write-port arbiter with stale-tag write suppression
module wb_arbiter #(
  parameter int N_REQ = 5,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic reset,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, STALL = 2'd2} state_t;
  state_t           r_state, w_next;
  logic [N_REQ-1:0] r_gnt, w_elig;
  logic [PW-1:0]    r_ptr, w_win;
  logic             r_we, w_go;
  logic [4:0]       r_waddr, w_addr;
  logic [31:0]      r_wdata, r_rel, w_data;
  logic [TAG_W-1:0] w_tag;
  assign w_elig = bus.i_req & ~r_gnt;
  assign w_go   = (|w_elig) && !bus.i_stall;
  // Scan downward so the lowest offset from r_ptr is the final (winning) assignment
  always_comb begin
    w_win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (w_elig[(int'(r_ptr) + i) % N_REQ]) w_win = PW'((int'(r_ptr) + i) % N_REQ);
  end
  assign w_addr = bus.i_addr[5*w_win +: 5];
  assign w_data = bus.i_data[32*w_win +: 32];
  assign w_tag  = bus.i_tag[TAG_W*w_win +: TAG_W];
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = !(|w_elig) ? IDLE : bus.i_stall ? STALL : GRANT;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_rel   <= '0;
    end else if (w_go) begin
      r_gnt   <= N_REQ'(1) << w_win;
      r_ptr   <= (w_win == PW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
      r_we    <= (w_addr != 5'd0) && (w_tag == bus.i_cur_tag);
      r_waddr <= w_addr;
      r_wdata <= w_data;
      r_rel   <= (w_addr != 5'd0) ? 32'(1) << w_addr : '0;
    end else begin
      r_gnt <= '0;
      r_we  <= 1'b0;
      r_rel <= '0;
    end
  end
  always_comb begin
    bus.o_gnt     = r_gnt;
    bus.o_we      = r_we;
    bus.o_waddr   = r_waddr;
    bus.o_wdata   = r_wdata;
    bus.o_release = r_rel;
    bus.o_state   = r_state;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table plus reset-mid-grant sequence for wb_arbiter
module tb_wb_arbiter;
  typedef struct {
    logic [4:0]  req;
    logic [24:0] addr;
    logic [19:0] tag;
    logic [3:0]  cur;
    logic        stall;
    logic [4:0]  gnt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rel;
    logic [1:0]  st;
  } vec_t;
  localparam logic [24:0] A  = {5'd9, 5'd8, 5'd7, 5'd6, 5'd5};
  localparam logic [24:0] A3 = {5'd9, 5'd8, 5'd7, 5'd3, 5'd5};
  localparam logic [24:0] A0 = {5'd9, 5'd0, 5'd7, 5'd6, 5'd5};
  localparam logic [19:0] T2 = 20'h00020;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t tv[24];
  wb_arbiter_if #(.N_REQ(5), .TAG_W(4)) bus ();
  wb_arbiter #(.N_REQ(5), .TAG_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [4:0] gnt, input logic we,
                         input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic [31:0] rel, input logic [1:0] st);
    chk({tag, ".gnt"}, 32'(bus.o_gnt), 32'(gnt));
    chk({tag, ".we"}, 32'(bus.o_we), 32'(we));
    chk({tag, ".waddr"}, 32'(bus.o_waddr), 32'(waddr));
    chk({tag, ".wdata"}, bus.o_wdata, wdata);
    chk({tag, ".release"}, bus.o_release, rel);
    chk({tag, ".state"}, 32'(bus.o_state), 32'(st));
  endtask
  initial begin
    for (int k = 0; k < 5; k++) bus.i_data[32*k +: 32] = 32'hDEADBEED + 32'(k);
    bus.i_req = '0; bus.i_addr = A; bus.i_tag = '0; bus.i_cur_tag = '0; bus.i_stall = 1'b0;
    tv[0]  = '{5'b11111, A,  20'h0, 4'd0, 1'b0, 5'b00001, 1'b1, 5'd5, 32'hDEADBEED, 32'h20,  2'd1};
    tv[1]  = '{5'b11110, A,  20'h0, 4'd0, 1'b0, 5'b00010, 1'b1, 5'd6, 32'hDEADBEEE, 32'h40,  2'd1};
    tv[2]  = '{5'b11101, A,  20'h0, 4'd0, 1'b0, 5'b00100, 1'b1, 5'd7, 32'hDEADBEEF, 32'h80,  2'd1};
    tv[3]  = '{5'b11011, A,  20'h0, 4'd0, 1'b0, 5'b01000, 1'b1, 5'd8, 32'hDEADBEF0, 32'h100, 2'd1};
    tv[4]  = '{5'b10111, A,  20'h0, 4'd0, 1'b0, 5'b10000, 1'b1, 5'd9, 32'hDEADBEF1, 32'h200, 2'd1};
    tv[5]  = '{5'b01111, A,  20'h0, 4'd0, 1'b0, 5'b00001, 1'b1, 5'd5, 32'hDEADBEED, 32'h20,  2'd1};
    tv[6]  = '{5'b00000, A,  20'h0, 4'd0, 1'b0, 5'b00000, 1'b0, 5'd5, 32'hDEADBEED, 32'h0,   2'd0};
    tv[7]  = '{5'b00100, A,  20'h0, 4'd0, 1'b0, 5'b00100, 1'b1, 5'd7, 32'hDEADBEEF, 32'h80,  2'd1};
    tv[8]  = '{5'b00000, A,  20'h0, 4'd0, 1'b0, 5'b00000, 1'b0, 5'd7, 32'hDEADBEEF, 32'h0,   2'd0};
    tv[9]  = '{5'b00100, A,  20'h0, 4'd0, 1'b0, 5'b00100, 1'b1, 5'd7, 32'hDEADBEEF, 32'h80,  2'd1};
    tv[10] = '{5'b00100, A,  20'h0, 4'd0, 1'b0, 5'b00000, 1'b0, 5'd7, 32'hDEADBEEF, 32'h0,   2'd0};
    tv[11] = '{5'b00100, A,  20'h0, 4'd0, 1'b0, 5'b00100, 1'b1, 5'd7, 32'hDEADBEEF, 32'h80,  2'd1};
    tv[12] = '{5'b00000, A,  20'h0, 4'd0, 1'b0, 5'b00000, 1'b0, 5'd7, 32'hDEADBEEF, 32'h0,   2'd0};
    tv[13] = '{5'b00010, A3, T2,    4'd5, 1'b0, 5'b00010, 1'b0, 5'd3, 32'hDEADBEEE, 32'h8,   2'd1};
    tv[14] = '{5'b00000, A3, T2,    4'd5, 1'b0, 5'b00000, 1'b0, 5'd3, 32'hDEADBEEE, 32'h0,   2'd0};
    tv[15] = '{5'b00010, A3, T2,    4'd2, 1'b0, 5'b00010, 1'b1, 5'd3, 32'hDEADBEEE, 32'h8,   2'd1};
    tv[16] = '{5'b00000, A,  20'h0, 4'd0, 1'b0, 5'b00000, 1'b0, 5'd3, 32'hDEADBEEE, 32'h0,   2'd0};
    tv[17] = '{5'b00010, A,  20'h0, 4'd0, 1'b1, 5'b00000, 1'b0, 5'd3, 32'hDEADBEEE, 32'h0,   2'd2};
    tv[18] = '{5'b00010, A,  20'h0, 4'd0, 1'b1, 5'b00000, 1'b0, 5'd3, 32'hDEADBEEE, 32'h0,   2'd2};
    tv[19] = '{5'b00010, A,  20'h0, 4'd0, 1'b1, 5'b00000, 1'b0, 5'd3, 32'hDEADBEEE, 32'h0,   2'd2};
    tv[20] = '{5'b00010, A,  20'h0, 4'd0, 1'b0, 5'b00010, 1'b1, 5'd6, 32'hDEADBEEE, 32'h40,  2'd1};
    tv[21] = '{5'b00000, A,  20'h0, 4'd0, 1'b0, 5'b00000, 1'b0, 5'd6, 32'hDEADBEEE, 32'h0,   2'd0};
    tv[22] = '{5'b01000, A0, 20'h0, 4'd0, 1'b0, 5'b01000, 1'b0, 5'd0, 32'hDEADBEF0, 32'h0,   2'd1};
    tv[23] = '{5'b00000, A0, 20'h0, 4'd0, 1'b0, 5'b00000, 1'b0, 5'd0, 32'hDEADBEF0, 32'h0,   2'd0};
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.i_req = tv[i].req; bus.i_addr = tv[i].addr; bus.i_tag = tv[i].tag;
      bus.i_cur_tag = tv[i].cur; bus.i_stall = tv[i].stall;
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), tv[i].gnt, tv[i].we, tv[i].waddr, tv[i].wdata, tv[i].rel, tv[i].st);
    end
    @(negedge clk);
    bus.i_req = 5'b01000; bus.i_addr = A; bus.i_tag = '0; bus.i_cur_tag = '0;
    @(posedge clk);
    #1 chk_all("pre_reset", 5'b01000, 1'b1, 5'd8, 32'hDEADBEF0, 32'h100, 2'd1);
    bus.i_req = 5'b11000;
    #2 reset = 1'b1;
    #1 chk_all("async_reset", 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 chk_all("post_reset", 5'b01000, 1'b1, 5'd8, 32'hDEADBEF0, 32'h100, 2'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
